// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with any depth (including non-power-of-two), a registered
// occupancy count, programmable almost-full/almost-empty flags, sticky
// overflow/underflow errors, a synchronous flush, and either a registered
// (standard) or first-word-fall-through read port.
module sync_fifo_ext #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 10,
    parameter  int FWFT       = 0,
    parameter  int AF_THRESH  = 8,
    parameter  int AE_THRESH  = 2,
    localparam int CW         = $clog2(DEPTH + 1),
    localparam int PW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
        AE_THRESH < 0 || AE_THRESH >= DEPTH || (FWFT != 0 && FWFT != 1)) begin : g_param_check
        $error("sync_fifo_ext: illegal parameter combination");
    end

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] w_ptr_q, w_ptr_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_ok, wr_ok;

    // Flags are decoded from the registered count only.
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A write at full is still accepted when a read frees a slot in the same cycle.
    assign rd_ok = r_en & ~empty;
    assign wr_ok = w_en & (~full | rd_ok);

    // Next-state: pointer wrap by compare, count update, sticky errors, flush clear.
    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            w_ptr_d     = '0;
            r_ptr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) begin
                w_ptr_d = (w_ptr_q == PTR_LAST) ? '0 : w_ptr_q + PW'(1);
            end
            if (rd_ok) begin
                r_ptr_d = (r_ptr_q == PTR_LAST) ? '0 : r_ptr_q + PW'(1);
            end
            if (wr_ok && !rd_ok) begin
                count_d = count_q + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - CW'(1);
            end
            if (w_en && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (r_en && !rd_ok) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write; contents are deliberately left untouched by reset and flush.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_ok) begin
            mem_q[w_ptr_q] <= data_in;
        end
    end

    if (FWFT == 0) begin : g_std
        logic [DATA_WIDTH-1:0] data_out_q;

        // Registered read: the old word at r_ptr is captured, even when the
        // same slot is rewritten at full in this cycle.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                data_out_q <= '0;
            end else if (rd_ok) begin
                data_out_q <= mem_q[r_ptr_q];
            end
        end

        assign data_out = data_out_q;
    end else begin : g_fwft
        // Head word is presented directly; r_en acknowledges it.
        assign data_out = empty ? '0 : mem_q[r_ptr_q];
    end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: a standard-mode and an FWFT-mode instance share one
// stimulus stream and are checked against a queue-based reference model, a
// table of hand-derived vectors, and a few hand-written sequences.
module tb_sync_fifo_ext;

    localparam int DW    = 32;
    localparam int DEPTH = 10;
    localparam int AF    = 8;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst, flush, w_en, r_en;
    logic [DW-1:0] data_in;

    logic [DW-1:0] dout_s, dout_f;
    logic          full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
    logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [3:0]    cnt_s, cnt_f;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    sync_fifo_ext #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) dut_std (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
        .almost_empty(ae_s), .count(cnt_s), .overflow(ovf_s), .underflow(unf_s));

    sync_fifo_ext #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
        .almost_empty(ae_f), .count(cnt_f), .overflow(ovf_f), .underflow(unf_f));

    // Reference model: contents as an ordered queue, plus sticky errors and
    // the last word handed out by an accepted read (standard mode output).
    logic [DW-1:0] m_q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_dout = '0;

    function automatic void model_step(input logic r, input logic f, input logic w,
                                       input logic [DW-1:0] d, input logic rd);
        bit acc_rd, acc_wr;
        if (r || f) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dout = '0;
        end else begin
            acc_rd = rd && (m_q.size() > 0);
            acc_wr = w && (m_q.size() < DEPTH || acc_rd);
            if (acc_rd) m_dout = m_q.pop_front();
            if (acc_wr) m_q.push_back(d);
            if (w && !acc_wr) m_ovf = 1'b1;
            if (rd && !acc_rd) m_unf = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = m_q.size();
        chk("count_std",  DW'(cnt_s),  DW'(sz));
        chk("count_fwft", DW'(cnt_f),  DW'(sz));
        chk("empty_std",  DW'(empty_s), DW'(sz == 0));
        chk("empty_fwft", DW'(empty_f), DW'(sz == 0));
        chk("full_std",   DW'(full_s),  DW'(sz == DEPTH));
        chk("full_fwft",  DW'(full_f),  DW'(sz == DEPTH));
        chk("af_std",     DW'(af_s),    DW'(sz >= AF));
        chk("af_fwft",    DW'(af_f),    DW'(sz >= AF));
        chk("ae_std",     DW'(ae_s),    DW'(sz <= AE));
        chk("ae_fwft",    DW'(ae_f),    DW'(sz <= AE));
        chk("ovf_std",    DW'(ovf_s),   DW'(m_ovf));
        chk("ovf_fwft",   DW'(ovf_f),   DW'(m_ovf));
        chk("unf_std",    DW'(unf_s),   DW'(m_unf));
        chk("unf_fwft",   DW'(unf_f),   DW'(m_unf));
        chk("dout_std",   dout_s,       m_dout);
        chk("dout_fwft",  dout_f,       (sz > 0) ? m_q[0] : '0);
    endtask

    // Apply one cycle of inputs (from a negedge), advance the model at the
    // posedge, and return at the following negedge ready for sampling.
    task automatic step(input logic r, input logic f, input logic w,
                        input logic [DW-1:0] d, input logic rd);
        rst = r; flush = f; w_en = w; data_in = d; r_en = rd;
        @(posedge clk);
        model_step(r, f, w, d, rd);
        @(negedge clk);
    endtask

    typedef struct {
        logic          rst, flush, w, r;
        logic [DW-1:0] d;
        int            cnt;
        logic [DW-1:0] dout;
        logic          ovf, unf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic f, input logic w, input logic rd,
                                input logic [DW-1:0] d, input int cnt, input logic [DW-1:0] dout,
                                input logic ovf, input logic unf);
        vec_t v;
        v.rst = r; v.flush = f; v.w = w; v.r = rd; v.d = d;
        v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.unf = unf;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [DW-1:0] base, dprev;
        logic          uprev;
        int            wp, rp;

        rst = 1'b1; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = '0;
        @(negedge clk);

        // Fill, overflow, drain, underflow.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) add(0, 0, 1, 0, DW'(k), k, 0, 0, 0);
        add(0, 0, 1, 0, 'hEE, 10, 0, 1, 0);
        for (int k = 1; k <= 10; k++) add(0, 0, 0, 1, 0, 10 - k, DW'(k), 1, 0);
        add(0, 0, 0, 1, 0, 0, 'hA, 1, 1);
        add(0, 1, 1, 1, 'h77, 0, 0, 0, 0);
        // Simultaneous read/write at full and at empty.
        for (int k = 0; k < 10; k++) add(0, 0, 1, 0, 'h11 + DW'(k), k + 1, 0, 0, 0);
        add(0, 0, 1, 1, 'hBB, 10, 'h11, 0, 0);
        for (int k = 1; k <= 9; k++) add(0, 0, 0, 1, 0, 10 - k, 'h11 + DW'(k), 0, 0);
        add(0, 0, 0, 1, 0, 0, 'hBB, 0, 0);
        add(0, 0, 1, 1, 'hCC, 1, 'hBB, 0, 1);
        add(0, 0, 0, 1, 0, 0, 'hCC, 0, 1);
        // Clear from count=6 with overflow set: flush, rst, rst+flush.
        for (int m = 0; m < 3; m++) begin
            base  = 'h21 + DW'(16 * m);
            dprev = (m == 0) ? 'hCC : '0;
            uprev = (m == 0);
            for (int k = 0; k < 10; k++) add(0, 0, 1, 0, base + DW'(k), k + 1, dprev, 0, uprev);
            add(0, 0, 1, 0, 'h99, 10, dprev, 1, uprev);
            for (int k = 1; k <= 4; k++) add(0, 0, 0, 1, 0, 10 - k, base + DW'(k - 1), 1, uprev);
            add((m > 0), (m != 1), 1, 1, 'h55, 0, 0, 0, 0);
        end

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].flush, tbl[i].w, tbl[i].d, tbl[i].r);
            chk("tbl_count", DW'(cnt_s), DW'(tbl[i].cnt));
            chk("tbl_dout",  dout_s,     tbl[i].dout);
            chk("tbl_ovf",   DW'(ovf_s), DW'(tbl[i].ovf));
            chk("tbl_unf",   DW'(unf_s), DW'(tbl[i].unf));
            chk("tbl_empty", DW'(empty_s), DW'(tbl[i].cnt == 0));
            chk("tbl_full",  DW'(full_s),  DW'(tbl[i].cnt == DEPTH));
            chk("tbl_af",    DW'(af_s),    DW'(tbl[i].cnt >= AF));
            chk("tbl_ae",    DW'(ae_s),    DW'(tbl[i].cnt <= AE));
            check_model();
        end

        // FWFT presentation sequence.
        step(1, 0, 0, 0, 0);
        chk("fwft_rst_dout", dout_f, 0);
        step(0, 0, 1, 'h55, 0);
        chk("fwft_first_empty", DW'(empty_f), 0);
        chk("fwft_first_dout", dout_f, 'h55);
        step(0, 0, 1, 'h66, 0);
        chk("fwft_hold_dout", dout_f, 'h55);
        step(0, 0, 0, 0, 1);
        chk("fwft_second_dout", dout_f, 'h66);
        chk("std_after_rd1", dout_s, 'h55);
        step(0, 0, 0, 0, 1);
        chk("fwft_drained_empty", DW'(empty_f), 1);
        chk("fwft_drained_dout", dout_f, 0);
        chk("std_after_rd2", dout_s, 'h66);

        // Wrap: hold occupancy at 5 while 30 words stream through.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 'h100 + DW'(k), 0);
        for (int k = 0; k < 30; k++) begin
            step(0, 0, 1, 'h200 + DW'(k), 1);
            chk("wrap_dout", dout_s, (k < 5) ? 'h100 + DW'(k) : 'h200 + DW'(k - 5));
            check_model();
        end
        chk("wrap_ovf", DW'(ovf_s), 0);
        chk("wrap_unf", DW'(unf_s), 0);

        // Randomised traffic with varying write/read bias.
        for (int ph = 0; ph < 4; ph++) begin
            wp = 30 + 20 * ph;
            rp = 80 - 20 * ph;
            for (int k = 0; k < 150; k++) begin
                step(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
                     ($urandom_range(0, 99) < wp), $urandom, ($urandom_range(0, 99) < rp));
                check_model();
            end
            for (int k = 0; k < 25; k++) begin
                step(0, 0, (ph < 2), $urandom, (ph >= 2));
                check_model();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Parametrised single-clock FIFO and the successor to the team's basic synchronous FIFO. It supports any depth, including non-power-of-two depths, with explicit pointer wrap. It adds a registered occupancy count, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, a synchronous flush, and a selectable output mode: standard registered read or first-word-fall-through (FWFT). It sits between producer and consumer stages in the same clock domain.

Parameters:
DATA_WIDTH, 32, width of each data word
DEPTH, 10, number of storage entries; must be >= 2; need not be a power of two
FWFT, 0, output mode: 0 = standard (registered read data), 1 = first-word-fall-through
AF_THRESH, 8, almost_full asserts when count >= AF_THRESH; must satisfy 1 <= AF_THRESH <= DEPTH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; must satisfy 0 <= AE_THRESH < DEPTH

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  synchronous clear of FIFO state
w_en  in  1  write request
data_in  in  DATA_WIDTH  write data
r_en  in  1  read request
data_out  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  CW  occupancy, where CW = $clog2(DEPTH+1)
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (rst=1 at a clk edge) sets w_ptr=0, r_ptr=0, count=0, overflow=0, underflow=0, and data_out=0 in FWFT=0 mode.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH >= 1).
  - Memory contents are not cleared.
- rst has priority over flush. flush has priority over w_en and r_en.
- flush=1 gives the same state result as reset. Requests in the flush cycle are ignored and set no error flags.
- Read acceptance: rd_ok = r_en & ~empty.
- Write acceptance: wr_ok = w_en & (~full | rd_ok).
  - A write while full is accepted when a read is accepted in the same cycle.
- Pointers are each $clog2(DEPTH) bits wide and increment on their accept. Each wraps from DEPTH-1 to 0 by compare, never by natural overflow.
- Count update:
  - wr_ok only: +1
  - rd_ok only: -1
  - both or neither: unchanged
  - count never exceeds DEPTH and never goes below 0.
- All flags are decoded from the registered count, so they change in the cycle after the accepted operation.
- Errors:
  - overflow is set on w_en & ~wr_ok.
  - underflow is set on r_en & ~rd_ok.
  - Both hold until rst or flush.
  - A rejected operation has no other effect: no pointer, count or memory change.
- Simultaneous operations at empty: the write is accepted, the read is rejected (underflow=1), and count becomes 1.
- Simultaneous operations at full: both are accepted, count stays DEPTH, and no error is flagged.
- FWFT=0 mode:
  - data_out <= mem[r_ptr] on rd_ok, so data is valid in the cycle after the accepted read.
  - data_out holds its value otherwise, including on a rejected read.
- FWFT=1 mode:
  - data_out = mem[r_ptr] whenever empty=0, and 0 when empty=1.
  - Write-to-visible latency is 1 cycle (empty deasserts together with the count update).
  - r_en acknowledges the displayed word, and the next word is displayed the following cycle.
- A write and a read to the same address in one cycle cannot occur except at full, where the read address holds the oldest word. The read returns the old data.
- Illegal parameter values cause an elaboration error via a generate-time check.

Test Plan:
1. DEPTH=10, FWFT=0, AF=8, after rst: write 0x1..0xA on consecutive cycles. Required: almost_full=1 once count=8; full=1 with count=10 after the 10th write. An 11th write gives overflow=1, count=10, and memory unchanged.
2. Continuing from 1: 10 consecutive reads. Required: data_out = 0x1..0xA, each one cycle after its r_en; empty=1 after the last; almost_empty=1 at count<=2. An extra read gives underflow=1 with data_out holding 0xA.
3. Wrap test: 30 interleaved writes/reads holding count between 3 and 7. Required: output order equals input order across multiple 9->0 pointer wraps, with no error flags.
4. At full (count=10), w_en=r_en=1 with data 0xBB. Required: the oldest word is output, count stays 10, overflow=0, and 0xBB is read out last. At empty, w_en=r_en=1 with 0xCC. Required: underflow=1, count=1, and the next read returns 0xCC.
5. FWFT=1, write 0x55 then 0x66. Required: the cycle after the first write shows empty=0 and data_out=0x55 with no r_en. After one r_en, data_out=0x66; after a second r_en, empty=1 and data_out=0.
6. With count=6 and overflow=1, assert flush with w_en=r_en=1. Required next cycle: count=0, empty=1, overflow=underflow=0. Repeat the same check using rst; rst asserted together with flush behaves identically.
